param_renamer: RTL and testbench

PARAM_RENAMER -- requirements
Module: param_renamer

---
 rtl/param_renamer_pkg.sv | 29 ++
 rtl/param_renamer_if.sv | 61 ++++++
 rtl/param_renamer_free_list.sv | 73 +++++++
 rtl/param_renamer_lutram.sv | 52 +++++
 rtl/param_renamer.sv | 182 ++++++++++++++++++
 tb/tb_param_renamer.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/param_renamer_pkg.sv
// Shared types for the register renamer: FSM state, default-width table entry
// views and the writeback-group width helper.
package cva5_types;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } renamer_state_t;

    // Entry views at the default configuration (64 physical registers, 2 groups).
    typedef logic [5:0] phys_addr_t;
    typedef logic [0:0] wb_group_t;

    typedef struct packed {
        phys_addr_t phys;
        wb_group_t  group;
    } spec_table_t;

    typedef struct packed {
        logic [4:0]  rd;
        phys_addr_t  phys;
        spec_table_t prev;
    } renamer_metadata_t;

    function automatic int group_width(input int groups);
        return (groups > 1) ? $clog2(groups) : 1;
    endfunction

endpackage

// File: rtl/param_renamer_if.sv
// Decode/issue/retire bus of the renamer. master drives requests into the
// renamer; slave is the renamer side.
interface param_renamer_if #(
    parameter int ARCH_REGS     = 32,
    parameter int PHYS_REGS     = 64,
    parameter int READ_PORTS    = 2,
    parameter int NUM_WB_GROUPS = 2,
    parameter int MAX_IDS       = 8
);
    import cva5_types::*;

    localparam int ARCH_W  = $clog2(ARCH_REGS);
    localparam int PHYS_W  = $clog2(PHYS_REGS);
    localparam int GROUP_W = group_width(NUM_WB_GROUPS);
    localparam int ID_W    = $clog2(MAX_IDS);
    localparam int COUNT_W = $clog2(PHYS_REGS) + 1;

    logic               flush;
    logic               rename_req;
    logic               rename_uses_rd;
    logic [ARCH_W-1:0]  rename_rd_addr;
    logic [GROUP_W-1:0] rename_rd_wb_group;
    logic [ARCH_W-1:0]  rename_rs_addr [READ_PORTS];
    logic               rename_ready;
    logic [PHYS_W-1:0]  phys_rs_addr [READ_PORTS];
    logic [GROUP_W-1:0] rs_wb_group [READ_PORTS];
    logic [PHYS_W-1:0]  phys_rd_addr;

    logic               issue_valid;
    logic               issue_uses_rd;
    logic [ARCH_W-1:0]  issue_rd_addr;
    logic [PHYS_W-1:0]  issue_phys_rd_addr;
    logic [ID_W-1:0]    issue_id;
    logic               issue_fire;

    logic               retire_valid;
    logic               retire_revert;
    logic [ID_W-1:0]    retire_id;

    logic               init_done;
    logic [COUNT_W-1:0] free_count;

    modport master (
        output flush, rename_req, rename_uses_rd, rename_rd_addr, rename_rd_wb_group,
               rename_rs_addr, issue_valid, issue_uses_rd, issue_rd_addr,
               issue_phys_rd_addr, issue_id, issue_fire, retire_valid,
               retire_revert, retire_id,
        input  rename_ready, phys_rs_addr, rs_wb_group, phys_rd_addr, init_done,
               free_count
    );

    modport slave (
        input  flush, rename_req, rename_uses_rd, rename_rd_addr, rename_rd_wb_group,
               rename_rs_addr, issue_valid, issue_uses_rd, issue_rd_addr,
               issue_phys_rd_addr, issue_id, issue_fire, retire_valid,
               retire_revert, retire_id,
        output rename_ready, phys_rs_addr, rs_wb_group, phys_rd_addr, init_done,
               free_count
    );

endinterface

// File: rtl/param_renamer_free_list.sv
// Circular free list of physical registers; rollback un-pops the last head.
module phys_free_list #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [$clog2(PHYS_REGS)-1:0] push_phys,
    input  logic                         pop,
    input  logic                         rollback,
    output logic [$clog2(PHYS_REGS)-1:0] head,
    output logic [$clog2(PHYS_REGS):0]   count
);
    localparam int DEPTH   = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PHYS_W  = $clog2(PHYS_REGS);
    localparam int COUNT_W = PHYS_W + 1;

    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
    endfunction

    lutram_1w_1r #(.WIDTH(PHYS_W), .DEPTH(DEPTH), .ADDR_W(PTR_W)) storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (push_phys),
        .raddr (rd_ptr_reg),
        .rdata (head)
    );

    always_comb begin
        count_next = count_reg + COUNT_W'(push) - COUNT_W'(pop) + COUNT_W'(rollback);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end else if (rollback) begin
                rd_ptr_reg <= ptr_dec(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && !pop && count_reg == COUNT_W'(DEPTH)));
            assert (!(pop && count_reg == '0));
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/param_renamer_lutram.sv
// Distributed-RAM building blocks: one write port, asynchronous read port(s).
module lutram_1w_1r #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

module lutram_1w_mr #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr [NUM_READ],
    output logic [WIDTH-1:0]  rdata [NUM_READ]
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            assign rdata[gi] = mem[raddr[gi]];
        end
    endgenerate
endmodule

// File: rtl/param_renamer.sv
// Register renamer: speculative map table, free list and per-ID in-use table
// supporting flush rollback and retire-time commit/revert.
module param_renamer
    import cva5_types::*;
#(
    parameter int ARCH_REGS     = 32,
    parameter int PHYS_REGS     = 64,
    parameter int READ_PORTS    = 2,
    parameter int NUM_WB_GROUPS = 2,
    parameter int MAX_IDS       = 8,
    parameter int RENAME_ZERO   = 0
) (
    input logic           clk,
    input logic           rst,
    param_renamer_if.slave bus
);
    localparam int ARCH_W     = $clog2(ARCH_REGS);
    localparam int PHYS_W     = $clog2(PHYS_REGS);
    localparam int GROUP_W    = group_width(NUM_WB_GROUPS);
    localparam int COUNT_W    = PHYS_W + 1;
    localparam int SPEC_PORTS = READ_PORTS + 1;

    typedef struct packed {
        logic [PHYS_W-1:0]  phys;
        logic [GROUP_W-1:0] group;
    } spec_entry_t;

    typedef struct packed {
        logic [ARCH_W-1:0] rd;
        logic [PHYS_W-1:0] phys;
        spec_entry_t       prev;
    } inuse_entry_t;

    localparam int SPEC_W  = $bits(spec_entry_t);
    localparam int INUSE_W = $bits(inuse_entry_t);

    renamer_state_t     state_reg;
    logic [PHYS_W-1:0]  init_count_reg;
    spec_entry_t        prev_reg;

    logic               in_init;
    logic               running;
    logic               init_arch;
    logic               ready;
    logic               rd_ok;
    logic               rename_active;
    logic               rollback;
    logic               revert_active;
    logic               fl_push;
    logic [PHYS_W-1:0]  fl_push_phys;
    logic [PHYS_W-1:0]  free_head;
    logic [COUNT_W-1:0] free_count;

    logic [ARCH_W-1:0]  spec_raddr [SPEC_PORTS];
    logic [SPEC_W-1:0]  spec_rdata [SPEC_PORTS];
    logic               spec_we;
    logic [ARCH_W-1:0]  spec_waddr;
    spec_entry_t        spec_wdata;
    spec_entry_t        spec_old;
    inuse_entry_t       inuse_wdata;
    logic [INUSE_W-1:0] inuse_rdata;
    inuse_entry_t       retire_entry;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= INIT;
            init_count_reg <= '0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (init_count_reg == PHYS_W'(PHYS_REGS - 1)) begin
                        state_reg <= RUN;
                    end
                    init_count_reg <= init_count_reg + PHYS_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_init   = (state_reg == INIT);
    assign running   = (state_reg == RUN);
    assign init_arch = (init_count_reg < PHYS_W'(ARCH_REGS));
    assign ready     = running && (free_count != '0);
    assign rd_ok     = (RENAME_ZERO != 0) || (bus.rename_rd_addr != '0);

    assign rename_active = bus.rename_req && ready && !bus.flush && bus.rename_uses_rd && rd_ok;
    assign rollback      = bus.flush && bus.issue_valid && bus.issue_uses_rd &&
                           ((RENAME_ZERO != 0) || (bus.issue_rd_addr != '0));
    assign revert_active = running && bus.retire_valid && bus.retire_revert;

    // During INIT the upper physical registers seed the free list; afterwards
    // retirement returns either the superseded mapping or the discarded one.
    assign fl_push      = in_init ? !init_arch : (running && bus.retire_valid);
    assign fl_push_phys = in_init ? init_count_reg :
                          (bus.retire_revert ? retire_entry.phys : retire_entry.prev.phys);

    phys_free_list #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS)) free_list (
        .clk       (clk),
        .rst       (rst),
        .push      (fl_push),
        .push_phys (fl_push_phys),
        .pop       (rename_active),
        .rollback  (rollback),
        .head      (free_head),
        .count     (free_count)
    );

    always_comb begin
        spec_we    = 1'b0;
        spec_waddr = bus.rename_rd_addr;
        spec_wdata = '{phys: free_head, group: bus.rename_rd_wb_group};
        if (in_init) begin
            spec_we    = init_arch;
            spec_waddr = init_count_reg[ARCH_W-1:0];
            spec_wdata = '{phys: init_count_reg, group: '0};
        end else if (revert_active) begin
            spec_we    = 1'b1;
            spec_waddr = retire_entry.rd;
            spec_wdata = retire_entry.prev;
        end else if (rollback) begin
            spec_we    = 1'b1;
            spec_waddr = bus.issue_rd_addr;
            spec_wdata = prev_reg;
        end else if (rename_active) begin
            spec_we    = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_src
            spec_entry_t src_entry;
            assign spec_raddr[gi]       = bus.rename_rs_addr[gi];
            assign src_entry            = spec_rdata[gi];
            assign bus.phys_rs_addr[gi] = src_entry.phys;
            assign bus.rs_wb_group[gi]  = src_entry.group;
        end
    endgenerate

    // The extra read port fetches the mapping being replaced by the rename.
    assign spec_raddr[READ_PORTS] = bus.rename_rd_addr;
    assign spec_old               = spec_rdata[READ_PORTS];

    lutram_1w_mr #(.WIDTH(SPEC_W), .DEPTH(ARCH_REGS), .NUM_READ(SPEC_PORTS), .ADDR_W(ARCH_W)) spec_table (
        .clk   (clk),
        .we    (spec_we),
        .waddr (spec_waddr),
        .wdata (spec_wdata),
        .raddr (spec_raddr),
        .rdata (spec_rdata)
    );

    always_ff @(posedge clk) begin
        if (rename_active) begin
            prev_reg <= spec_old;
        end
    end

    assign inuse_wdata  = '{rd: bus.issue_rd_addr, phys: bus.issue_phys_rd_addr, prev: prev_reg};
    assign retire_entry = inuse_rdata;

    lutram_1w_1r #(.WIDTH(INUSE_W), .DEPTH(MAX_IDS)) inuse_table (
        .clk   (clk),
        .we    (bus.issue_fire),
        .waddr (bus.issue_id),
        .wdata (inuse_wdata),
        .raddr (bus.retire_id),
        .rdata (inuse_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(bus.flush && bus.retire_revert));
        end
    end

    assign bus.rename_ready = ready;
    assign bus.phys_rd_addr = rd_ok ? free_head : '0;
    assign bus.init_done    = running;
    assign bus.free_count   = free_count;
endmodule

// File: tb/tb_param_renamer.sv
// Directed bench for param_renamer: a 64-register instance for the main flows
// and a 48-register instance for free-list exhaustion.
module tb_param_renamer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_renamer_if #(.PHYS_REGS(64)) bus_a ();
    param_renamer_if #(.PHYS_REGS(48)) bus_b ();

    param_renamer #(.PHYS_REGS(64)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    param_renamer #(.PHYS_REGS(48)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic flush;
        logic req;
        logic uses_rd;
        int   rd;
        int   grp;
        int   rs0;
        int   rs1;
        int   exp_rd_phys;
        int   exp_rs0;
        int   exp_rs1;
        int   exp_count;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.flush = 0; bus_a.rename_req = 0; bus_a.rename_uses_rd = 0;
        bus_a.rename_rd_addr = 0; bus_a.rename_rd_wb_group = 0;
        bus_a.rename_rs_addr[0] = 0; bus_a.rename_rs_addr[1] = 0;
        bus_a.issue_valid = 0; bus_a.issue_uses_rd = 0; bus_a.issue_rd_addr = 0;
        bus_a.issue_phys_rd_addr = 0; bus_a.issue_id = 0; bus_a.issue_fire = 0;
        bus_a.retire_valid = 0; bus_a.retire_revert = 0; bus_a.retire_id = 0;
    endtask

    task automatic idle_b();
        bus_b.flush = 0; bus_b.rename_req = 0; bus_b.rename_uses_rd = 0;
        bus_b.rename_rd_addr = 0; bus_b.rename_rd_wb_group = 0;
        bus_b.rename_rs_addr[0] = 0; bus_b.rename_rs_addr[1] = 0;
        bus_b.issue_valid = 0; bus_b.issue_uses_rd = 0; bus_b.issue_rd_addr = 0;
        bus_b.issue_phys_rd_addr = 0; bus_b.issue_id = 0; bus_b.issue_fire = 0;
        bus_b.retire_valid = 0; bus_b.retire_revert = 0; bus_b.retire_id = 0;
    endtask

    task automatic rename_a(input int rd, input int grp);
        bus_a.rename_req = 1; bus_a.rename_uses_rd = 1;
        bus_a.rename_rd_addr = 5'(rd); bus_a.rename_rd_wb_group = 1'(grp);
    endtask

    initial begin
        // flush, req, uses_rd, rd, grp, rs0, rs1, exp_rd_phys, exp_rs0, exp_rs1, exp_count
        vecs[0] = '{1'b0, 1'b1, 1'b1,  0, 0,  5,  6,  0,  5,  6, 32};
        vecs[1] = '{1'b0, 1'b1, 1'b0,  5, 1,  0, 31, 32,  0, 31, 32};
        vecs[2] = '{1'b0, 1'b0, 1'b1,  5, 0, 17,  1, 32, 17,  1, 32};
        vecs[3] = '{1'b0, 1'b1, 1'b1,  0, 1, 31, 30,  0, 31, 30, 32};
        vecs[4] = '{1'b1, 1'b1, 1'b1,  5, 0, 12, 20, 32, 12, 20, 32};

        rst = 0;
        idle_a();
        idle_b();
        repeat (3) tick();
        check("reset init_done", int'(bus_a.init_done), 0);
        check("reset free_count", int'(bus_a.free_count), 0);
        check("reset rename_ready", int'(bus_a.rename_ready), 0);

        rst = 1;
        repeat (63) tick();
        check("init cycle63 init_done", int'(bus_a.init_done), 0);
        tick();
        check("init cycle64 init_done", int'(bus_a.init_done), 1);
        check("init free_count", int'(bus_a.free_count), 32);
        check("init rename_ready", int'(bus_a.rename_ready), 1);
        check("init b free_count", int'(bus_b.free_count), 16);

        // Table: source reads, x0 / non-rd / flushed requests that must not pop.
        for (int i = 0; i < 5; i++) begin
            bus_a.flush = vecs[i].flush;
            bus_a.rename_req = vecs[i].req;
            bus_a.rename_uses_rd = vecs[i].uses_rd;
            bus_a.rename_rd_addr = 5'(vecs[i].rd);
            bus_a.rename_rd_wb_group = 1'(vecs[i].grp);
            bus_a.rename_rs_addr[0] = 5'(vecs[i].rs0);
            bus_a.rename_rs_addr[1] = 5'(vecs[i].rs1);
            #1;
            check($sformatf("vec%0d phys_rd", i), int'(bus_a.phys_rd_addr), vecs[i].exp_rd_phys);
            check($sformatf("vec%0d rs0", i), int'(bus_a.phys_rs_addr[0]), vecs[i].exp_rs0);
            check($sformatf("vec%0d rs1", i), int'(bus_a.phys_rs_addr[1]), vecs[i].exp_rs1);
            check($sformatf("vec%0d rs0 group", i), int'(bus_a.rs_wb_group[0]), 0);
            tick();
            check($sformatf("vec%0d free_count", i), int'(bus_a.free_count), vecs[i].exp_count);
        end
        idle_a();

        // Rename x7 then roll it back with a flushed issue of x7.
        rename_a(7, 0);
        bus_a.rename_rs_addr[0] = 7;
        #1;
        check("rb rename phys_rd", int'(bus_a.phys_rd_addr), 32);
        check("rb rs x7 same cycle", int'(bus_a.phys_rs_addr[0]), 7);
        tick();
        check("rb free_count after pop", int'(bus_a.free_count), 31);
        check("rb rs x7 renamed", int'(bus_a.phys_rs_addr[0]), 32);
        idle_a();
        bus_a.flush = 1; bus_a.issue_valid = 1; bus_a.issue_uses_rd = 1; bus_a.issue_rd_addr = 7;
        tick();
        idle_a();
        bus_a.rename_rs_addr[0] = 7;
        #1;
        check("rb rs x7 restored", int'(bus_a.phys_rs_addr[0]), 7);
        check("rb free_count restored", int'(bus_a.free_count), 32);

        // Rename x9 (group 1), issue as ID 2, then revert it at retire.
        rename_a(9, 1);
        bus_a.rename_rs_addr[0] = 9;
        #1;
        check("rv rename phys_rd", int'(bus_a.phys_rd_addr), 32);
        tick();
        check("rv rs x9 renamed", int'(bus_a.phys_rs_addr[0]), 32);
        check("rv rs x9 group", int'(bus_a.rs_wb_group[0]), 1);
        idle_a();
        bus_a.issue_valid = 1; bus_a.issue_uses_rd = 1; bus_a.issue_fire = 1;
        bus_a.issue_id = 2; bus_a.issue_rd_addr = 9; bus_a.issue_phys_rd_addr = 32;
        tick();
        idle_a();
        bus_a.retire_valid = 1; bus_a.retire_revert = 1; bus_a.retire_id = 2;
        tick();
        idle_a();
        bus_a.rename_rs_addr[0] = 9;
        #1;
        check("rv rs x9 restored", int'(bus_a.phys_rs_addr[0]), 9);
        check("rv rs x9 group restored", int'(bus_a.rs_wb_group[0]), 0);
        check("rv free_count", int'(bus_a.free_count), 32);

        // Rename x3 (ID 1), then commit ID 1 while renaming x4 in the same cycle.
        rename_a(3, 0);
        #1;
        check("cm rename x3 phys_rd", int'(bus_a.phys_rd_addr), 33);
        tick();
        idle_a();
        bus_a.issue_valid = 1; bus_a.issue_uses_rd = 1; bus_a.issue_fire = 1;
        bus_a.issue_id = 1; bus_a.issue_rd_addr = 3; bus_a.issue_phys_rd_addr = 33;
        tick();
        idle_a();
        bus_a.retire_valid = 1; bus_a.retire_id = 1;
        rename_a(4, 0);
        #1;
        check("cm rename x4 phys_rd", int'(bus_a.phys_rd_addr), 34);
        tick();
        idle_a();
        #1;
        check("cm free_count unchanged", int'(bus_a.free_count), 31);

        // Drain: FIFO order ends with the reverted 32 and the committed old x3 mapping.
        for (int k = 0; k < 31; k++) begin
            rename_a(3, 0);
            #1;
            check($sformatf("drain%0d phys_rd", k), int'(bus_a.phys_rd_addr),
                  (k < 29) ? 35 + k : ((k == 29) ? 32 : 3));
            tick();
            check($sformatf("drain%0d free_count", k), int'(bus_a.free_count), 30 - k);
        end
        idle_a();
        bus_a.rename_rs_addr[0] = 3;
        #1;
        check("drain rename_ready", int'(bus_a.rename_ready), 0);
        check("drain rs x3", int'(bus_a.phys_rs_addr[0]), 3);

        // 48-register instance: 17 back-to-back renames of x3, only 16 accepted.
        for (int k = 0; k < 16; k++) begin
            bus_b.rename_req = 1; bus_b.rename_uses_rd = 1; bus_b.rename_rd_addr = 3;
            #1;
            check($sformatf("b ren%0d ready", k), int'(bus_b.rename_ready), 1);
            check($sformatf("b ren%0d phys_rd", k), int'(bus_b.phys_rd_addr), 32 + k);
            tick();
        end
        #1;
        check("b ren16 ready", int'(bus_b.rename_ready), 0);
        tick();
        check("b exhausted free_count", int'(bus_b.free_count), 0);
        idle_b();

        // Reset in RUN restarts initialisation from scratch.
        rst = 0;
        tick();
        check("rerst init_done", int'(bus_a.init_done), 0);
        check("rerst free_count", int'(bus_a.free_count), 0);
        check("rerst rename_ready", int'(bus_a.rename_ready), 0);
        rst = 1;
        repeat (63) tick();
        check("rerst cycle63 init_done", int'(bus_a.init_done), 0);
        tick();
        bus_a.rename_rs_addr[0] = 3;
        bus_a.rename_rs_addr[1] = 4;
        #1;
        check("rerst cycle64 init_done", int'(bus_a.init_done), 1);
        check("rerst free_count", int'(bus_a.free_count), 32);
        check("rerst rs x3", int'(bus_a.phys_rs_addr[0]), 3);
        check("rerst rs x4", int'(bus_a.phys_rs_addr[1]), 4);
        check("rerst b free_count", int'(bus_b.free_count), 16);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
